// File: rtl/pipeline_stall_ctrl.sv
// Hazard/stall controller for a 5-stage pipeline: load-use bubbles, branch flushes, D-cache miss waits.
// Optional macro STALL_CNT_EN adds a saturating 16-bit counter of cycles with pcwrite low.
module pipeline_stall_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        IDEXmemread,
    input  logic [4:0]  IDEXrtaddr,
    input  logic [4:0]  IFIDrsaddr,
    input  logic [4:0]  IFIDrtaddr,
    input  logic        branch_taken_i,
    input  logic        mem_req_i,
    input  logic        mem_ack_i,
    output logic        pcwrite,
    output logic        IFIDwrite,
    output logic        IFIDflush,
    output logic        bubble_ctrl,
    output logic        stage_stall,
    output logic [15:0] stall_cnt,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        FLUSH   = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   flush_pend_q, flush_pend_d;
    logic   load_use;

    assign load_use = IDEXmemread && (IDEXrtaddr != 5'd0) &&
                      ((IDEXrtaddr == IFIDrsaddr) || (IDEXrtaddr == IFIDrtaddr));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    always_comb begin
        state_d      = RUN;
        flush_pend_d = flush_pend_q;
        pcwrite      = 1'b1;
        IFIDwrite    = 1'b1;
        IFIDflush    = 1'b0;
        bubble_ctrl  = 1'b0;
        stage_stall  = 1'b0;
        case (state_q)
            MEMWAIT: begin
                pcwrite     = 1'b0;
                IFIDwrite   = 1'b0;
                stage_stall = 1'b1;
                state_d     = MEMWAIT;
                // A branch resolved while frozen is redirected once memory returns.
                if (branch_taken_i) flush_pend_d = 1'b1;
                if (mem_ack_i) state_d = (flush_pend_q || branch_taken_i) ? FLUSH : RUN;
            end
            FLUSH: begin
                IFIDflush    = 1'b1;
                flush_pend_d = 1'b0;
                state_d      = RUN;
            end
            default: begin
                if (mem_req_i) begin
                    pcwrite     = 1'b0;
                    IFIDwrite   = 1'b0;
                    stage_stall = 1'b1;
                    state_d     = MEMWAIT;
                end else if (load_use) begin
                    // Branch is dropped here; the core re-presents it next cycle.
                    pcwrite     = 1'b0;
                    IFIDwrite   = 1'b0;
                    bubble_ctrl = 1'b1;
                end else if (branch_taken_i) begin
                    IFIDflush = 1'b1;
                end
            end
        endcase
        if (!rst_i) begin
            pcwrite     = 1'b1;
            IFIDwrite   = 1'b1;
            IFIDflush   = 1'b0;
            bubble_ctrl = 1'b0;
            stage_stall = 1'b0;
        end
    end

    assign state_o = state_q;

`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pcwrite && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) stall_cnt_q <= 16'd0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Randomized and directed bench for pipeline_stall_ctrl against a cycle-level behavioural model.
module tb_pipeline_stall_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        IDEXmemread;
    logic [4:0]  IDEXrtaddr, IFIDrsaddr, IFIDrtaddr;
    logic        branch_taken_i, mem_req_i, mem_ack_i;
    logic        pcwrite, IFIDwrite, IFIDflush, bubble_ctrl, stage_stall;
    logic [15:0] stall_cnt;
    logic [1:0]  state_o;

    pipeline_stall_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .IDEXmemread(IDEXmemread), .IDEXrtaddr(IDEXrtaddr),
        .IFIDrsaddr(IFIDrsaddr), .IFIDrtaddr(IFIDrtaddr),
        .branch_taken_i(branch_taken_i), .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
        .pcwrite(pcwrite), .IFIDwrite(IFIDwrite), .IFIDflush(IFIDflush),
        .bubble_ctrl(bubble_ctrl), .stage_stall(stage_stall),
        .stall_cnt(stall_cnt), .state_o(state_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: waiting on memory, branch owed from the wait, redirect cycle due now.
    bit waiting   = 0;
    bit owed      = 0;
    bit redirect  = 0;
    int exp_cnt   = 0;

    // Output vector order: {pcwrite, IFIDwrite, IFIDflush, bubble_ctrl, stage_stall}
    localparam logic [4:0] O_FLOW   = 5'b11000;
    localparam logic [4:0] O_FLUSH  = 5'b11100;
    localparam logic [4:0] O_FREEZE = 5'b00001;
    localparam logic [4:0] O_BUBBLE = 5'b00010;

    task automatic step(input string tag, input bit rst_n, input bit mr, input bit ack,
                        input bit br, input bit mrd, input logic [4:0] rt,
                        input logic [4:0] rs, input logic [4:0] ft);
        logic [4:0] exp_o;
        bit hazard;
        @(negedge clk_i);
        rst_i = rst_n; mem_req_i = mr; mem_ack_i = ack; branch_taken_i = br;
        IDEXmemread = mrd; IDEXrtaddr = rt; IFIDrsaddr = rs; IFIDrtaddr = ft;
        #1;
        hazard = mrd && (rt != 0) && (rt == rs || rt == ft);
        if (!rst_n)        exp_o = O_FLOW;
        else if (redirect) exp_o = O_FLUSH;
        else if (waiting)  exp_o = O_FREEZE;
        else if (mr)       exp_o = O_FREEZE;
        else if (hazard)   exp_o = O_BUBBLE;
        else if (br)       exp_o = O_FLUSH;
        else               exp_o = O_FLOW;
        if (!rst_n) exp_cnt = 0;
        check({tag, ".outs"}, {11'd0, pcwrite, IFIDwrite, IFIDflush, bubble_ctrl, stage_stall},
              {11'd0, exp_o});
`ifdef STALL_CNT_EN
        check({tag, ".cnt"}, stall_cnt, exp_cnt[15:0]);
`else
        check({tag, ".cnt"}, stall_cnt, 16'd0);
`endif
        if (!rst_n) begin
            waiting = 0; owed = 0; redirect = 0;
        end else begin
            if (!exp_o[4] && exp_cnt < 65535) exp_cnt++;
            if (redirect) begin
                redirect = 0; owed = 0;
            end else if (waiting) begin
                owed = owed | br;
                if (ack) begin
                    waiting  = 0;
                    redirect = owed;
                end
            end else if (mr) begin
                waiting = 1;
            end
        end
    endtask

    task automatic idle(input string tag);
        step(tag, 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    endtask

    int miss_left;
    bit rr, mr, ack;

    initial begin
        step("reset", 0, 1, 0, 1, 1, 5'd3, 5'd3, 5'd0);
        idle("post_reset");

        // Load-use bubble, then x0 destination does not stall
        step("lu_hit", 1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd7);
        step("lu_x0", 1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
        step("lu_rt", 1, 0, 0, 1, 1, 5'd9, 5'd1, 5'd9);
        step("br_only", 1, 0, 0, 1, 0, 5'd9, 5'd9, 5'd9);

        // Four-cycle miss with counter from zero
        step("rst_cnt", 0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("miss1", 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("miss2", 1, 1, 0, 0, 1, 5'd4, 5'd4, 5'd0);
        step("miss3", 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("miss4", 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        idle("miss_run");
        // Back-to-back miss right after ack, with a stray ack in RUN first
        step("stray_ack", 1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        step("b2b1", 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("b2b2", 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        step("b2b3", 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("b2b4", 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        idle("b2b_run");

        // Branch during the wait becomes a one-cycle flush after ack
        step("bw1", 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("bw2", 1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        step("bw3", 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        step("bw4_flush", 1, 0, 1, 0, 1, 5'd2, 5'd2, 5'd0);
        step("bw5", 1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);

        // Miss, load-use and branch all at once
        step("all3", 1, 1, 0, 1, 1, 5'd6, 5'd6, 5'd6);
        step("all3_ack", 1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
        idle("all3_run");

        // Reset with a pending flush abandons both
        step("rp1", 1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        step("rp2", 1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0);
        step("rp_rst", 0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
        idle("rp_after1");
        idle("rp_after2");

        miss_left = 0;
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 199) != 0);
            if (!rr) miss_left = 0;
            if (rr && miss_left == 0 && !waiting && !redirect && $urandom_range(0, 5) == 0)
                miss_left = $urandom_range(2, 6);
            mr  = (miss_left > 0);
            ack = (miss_left == 1) || (miss_left == 0 && $urandom_range(0, 15) == 0);
            step("rand", rr, mr, ack, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
            if (miss_left > 0) miss_left--;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
